ibex_csr_err_monitor: RTL and testbench

//  Consumer side of shadowed CSR integrity: collects rd_error from NumCsr shadowed CSR primitives.

---
 rtl/ibex_csr_err_monitor_pkg.sv | 14 +
 rtl/ibex_csr.sv | 46 ++++
 rtl/ibex_csr_err_monitor.sv | 176 +++++++++++++++++
 tb/tb_ibex_csr_err_monitor.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ibex_csr_err_monitor_pkg.sv
// Shared types for the shadowed-CSR error monitor.
package ibex_csr_err_monitor_pkg;

  localparam int unsigned CsrMonCntW = 4;

  typedef enum logic [2:0] {
    CSR_MON_IDLE   = 3'd0,
    CSR_MON_FILTER = 3'd1,
    CSR_MON_ALERT  = 3'd2,
    CSR_MON_HOLD   = 3'd3,
    CSR_MON_DONE   = 3'd4
  } csr_mon_state_e;

endpackage

// File: rtl/ibex_csr.sv
// Simple CSR storage element with an optional inverted shadow copy.
// rd_error_o flags any disagreement between the primary and shadow copies.
module ibex_csr #(
  parameter int unsigned      Width      = 32,
  parameter bit               ShadowCopy = 1'b0,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             wr_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             rd_error_o
);

  logic [Width-1:0] rdata_q;

  // Primary copy: loaded on every write enable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= ResetValue;
    end else if (wr_en_i) begin
      rdata_q <= wr_data_i;
    end
  end

  assign rd_data_o = rdata_q;

  if (ShadowCopy) begin : g_shadow
    logic [Width-1:0] shadow_q;

    // Shadow copy holds the bitwise inverse so a common-mode upset is detectable.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        shadow_q <= ~ResetValue;
      end else if (wr_en_i) begin
        shadow_q <= ~wr_data_i;
      end
    end

    assign rd_error_o = (rdata_q != ~shadow_q);
  end else begin : g_no_shadow
    assign rd_error_o = 1'b0;
  end

endmodule

// File: rtl/ibex_csr_err_monitor.sv
// Collects rd_error lines from shadowed CSRs, filters transients with a
// consecutive-cycle threshold, latches a sticky error vector and raises a
// fatal alert over a four-phase req/ack handshake.
module ibex_csr_err_monitor
  import ibex_csr_err_monitor_pkg::*;
#(
  parameter int unsigned NumCsr    = 8,
  parameter int unsigned Threshold = 2,
  localparam int unsigned IdxW     = (NumCsr > 2) ? $clog2(NumCsr) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic [NumCsr-1:0] err_i,
  input  logic              clear_i,
  input  logic              alert_ack_i,
  output logic              alert_req_o,
  output logic              fatal_o,
  output logic [NumCsr-1:0] err_vec_o,
  output logic [IdxW-1:0]   err_idx_o
);

  localparam logic [CsrMonCntW-1:0] ThrCnt    = CsrMonCntW'(Threshold);
  localparam logic [CsrMonCntW-1:0] ThrCntM1  = CsrMonCntW'(Threshold - 1);
  localparam bit                    Immediate = (Threshold == 1);

  csr_mon_state_e         state_q, state_d;
  logic [CsrMonCntW-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic                   req_q, fatal_q;
  logic [NumCsr-1:0]      masked_err;
  logic                   any_err;
  logic [IdxW-1:0]        low_idx;
  logic                   vec_wr_en;
  logic [NumCsr-1:0]      vec_wr_data;
  logic [NumCsr-1:0]      vec_q;
  logic                   vec_err;

  assign masked_err = err_i & {NumCsr{enable_i}};
  assign any_err    = |masked_err;

  // Lowest set index of the masked error lines.
  always_comb begin
    low_idx = '0;
    for (int unsigned i = NumCsr; i > 0; i--) begin
      if (masked_err[i-1]) begin
        low_idx = IdxW'(i - 1);
      end
    end
  end

  // Next-state, counter and sticky-vector update logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    vec_wr_en   = 1'b0;
    vec_wr_data = vec_q | masked_err;
    if (!any_err) begin
      cnt_d = '0;
    end else if (cnt_q < ThrCnt) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      CSR_MON_IDLE: begin
        if (clear_i) begin
          cnt_d       = '0;
          idx_d       = '0;
          vec_wr_en   = 1'b1;
          vec_wr_data = '0;
        end else if (any_err) begin
          if (Immediate) begin
            state_d     = CSR_MON_ALERT;
            vec_wr_en   = 1'b1;
            vec_wr_data = masked_err;
            idx_d       = low_idx;
          end else begin
            state_d = CSR_MON_FILTER;
          end
        end
      end
      CSR_MON_FILTER: begin
        // Clear takes priority over a coincident trigger.
        if (clear_i) begin
          state_d     = CSR_MON_IDLE;
          cnt_d       = '0;
          idx_d       = '0;
          vec_wr_en   = 1'b1;
          vec_wr_data = '0;
        end else if (!any_err) begin
          state_d = CSR_MON_IDLE;
        end else if (cnt_q == ThrCntM1) begin
          state_d     = CSR_MON_ALERT;
          vec_wr_en   = 1'b1;
          vec_wr_data = masked_err;
          idx_d       = low_idx;
        end
      end
      CSR_MON_ALERT: begin
        vec_wr_en = 1'b1;
        if (alert_ack_i) begin
          state_d = CSR_MON_HOLD;
        end
      end
      CSR_MON_HOLD: begin
        vec_wr_en = 1'b1;
        if (!alert_ack_i) begin
          state_d = CSR_MON_DONE;
        end
      end
      CSR_MON_DONE: begin
        if (clear_i) begin
          state_d     = CSR_MON_IDLE;
          cnt_d       = '0;
          idx_d       = '0;
          vec_wr_en   = 1'b1;
          vec_wr_data = '0;
        end else begin
          vec_wr_en = 1'b1;
        end
      end
      default: begin
        state_d = CSR_MON_DONE;
      end
    endcase

    // A corrupted shadow copy of the error vector is itself fatal.
    if (vec_err) begin
      state_d = CSR_MON_DONE;
    end
  end

  // State, counter, index and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= CSR_MON_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      req_q   <= 1'b0;
      fatal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      req_q   <= (state_d == CSR_MON_ALERT);
      fatal_q <= (state_d == CSR_MON_DONE);
    end
  end

  ibex_csr #(
    .Width      (NumCsr),
    .ShadowCopy (1'b1),
    .ResetValue ('0)
  ) u_err_vec_csr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_data_i  (vec_wr_data),
    .wr_en_i    (vec_wr_en),
    .rd_data_o  (vec_q),
    .rd_error_o (vec_err)
  );

  assign alert_req_o = req_q;
  assign fatal_o     = fatal_q;
  assign err_vec_o   = vec_q;
  assign err_idx_o   = idx_q;

  a_inputs_known: assert property (@(posedge clk_i) disable iff (rst_i)
    !$isunknown({err_i, enable_i, alert_ack_i}));

  a_req_rise_only_in_alert: assert property (@(posedge clk_i) disable iff (rst_i)
    $rose(req_q) |-> (state_q == CSR_MON_ALERT));

endmodule

// File: tb/tb_ibex_csr_err_monitor.sv
// Scoreboard bench for ibex_csr_err_monitor: two instances (Threshold 2 and 1)
// share stimulus; expected outputs are queued with each stimulus cycle.
module tb_ibex_csr_err_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] err_in = '0;
  logic       clear = 1'b0;
  logic       ack_in = 1'b0;

  logic       req0, fat0, req1, fat1;
  logic [7:0] vec0, vec1;
  logic [2:0] idx0, idx1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      tag;
    bit         sel;
    logic       req;
    logic       fatal;
    logic [7:0] vec;
    logic [2:0] idx;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;

  always #5 clk = ~clk;

  ibex_csr_err_monitor #(.NumCsr(8), .Threshold(2)) u_dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .err_i(err_in),
    .clear_i(clear), .alert_ack_i(ack_in), .alert_req_o(req0),
    .fatal_o(fat0), .err_vec_o(vec0), .err_idx_o(idx0)
  );

  ibex_csr_err_monitor #(.NumCsr(8), .Threshold(1)) u_dut_t1 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .err_i(err_in),
    .clear_i(clear), .alert_ack_i(ack_in), .alert_req_o(req1),
    .fatal_o(fat1), .err_vec_o(vec1), .err_idx_o(idx1)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the next edge.
  task automatic drv(input string tag, input logic en, input logic [7:0] err,
                     input logic clr, input logic ack, input bit sel,
                     input logic ereq, input logic efat, input logic [7:0] evec,
                     input logic [2:0] eidx);
    exp_t x;
    @(negedge clk);
    enable = en;
    err_in = err;
    clear  = clr;
    ack_in = ack;
    x.tag = tag; x.sel = sel; x.req = ereq; x.fatal = efat; x.vec = evec; x.idx = eidx;
    sb_q.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; err_in = '0; clear = 1'b0; ack_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst.req0", 32'(req0), 32'd0);
    check_val("rst.fat0", 32'(fat0), 32'd0);
    check_val("rst.vec0", 32'(vec0), 32'd0);
    check_val("rst.idx0", 32'(idx0), 32'd0);
    check_val("rst.req1", 32'(req1), 32'd0);
    check_val("rst.vec1", 32'(vec1), 32'd0);
  endtask

  // Monitor: compare the oldest expectation shortly after each active edge.
  always @(posedge clk) begin
    #2;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      if (!e.sel) begin
        check_val({e.tag, ".req"},   32'(req0), 32'(e.req));
        check_val({e.tag, ".fatal"}, 32'(fat0), 32'(e.fatal));
        check_val({e.tag, ".vec"},   32'(vec0), 32'(e.vec));
        check_val({e.tag, ".idx"},   32'(idx0), 32'(e.idx));
      end else begin
        check_val({e.tag, ".req1"},   32'(req1), 32'(e.req));
        check_val({e.tag, ".fatal1"}, 32'(fat1), 32'(e.fatal));
        check_val({e.tag, ".vec1"},   32'(vec1), 32'(e.vec));
        check_val({e.tag, ".idx1"},   32'(idx1), 32'(e.idx));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();

    // Single-cycle error is filtered out.
    drv("t1a", 1, 8'h04, 0, 0, 0, 0, 0, 8'h00, 0);
    drv("t1b", 1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0);
    drv("t1c", 1, 8'h04, 0, 0, 0, 0, 0, 8'h00, 0);
    drv("t1d", 1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0);
    drv("t1e", 1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0);

    // Sustained error: alert, handshake, sticky accumulation, clear.
    drv("t2a", 1, 8'h14, 0, 0, 0, 0, 0, 8'h00, 0);
    drv("t2b", 1, 8'h14, 0, 0, 0, 1, 0, 8'h14, 2);
    drv("t2c", 1, 8'h14, 0, 0, 0, 1, 0, 8'h14, 2);
    drv("t2d", 1, 8'h14, 0, 0, 0, 1, 0, 8'h14, 2);
    drv("t2e", 1, 8'h14, 0, 1, 0, 0, 0, 8'h14, 2);
    drv("t2f", 1, 8'h14, 0, 1, 0, 0, 0, 8'h14, 2);
    drv("t2g", 1, 8'h14, 0, 0, 0, 0, 1, 8'h14, 2);
    drv("t2h", 1, 8'h01, 0, 0, 0, 0, 1, 8'h15, 2);
    drv("t2i", 0, 8'h80, 0, 0, 0, 0, 1, 8'h15, 2);
    drv("t2j", 1, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0);

    // Ack already high at trigger: one-cycle request.
    drv("t3a", 1, 8'h80, 0, 1, 0, 0, 0, 8'h00, 0);
    drv("t3b", 1, 8'h80, 0, 1, 0, 1, 0, 8'h80, 7);
    drv("t3c", 1, 8'h80, 0, 1, 0, 0, 0, 8'h80, 7);
    drv("t3d", 1, 8'h00, 0, 1, 0, 0, 0, 8'h80, 7);
    drv("t3e", 1, 8'h00, 0, 0, 0, 0, 1, 8'h80, 7);
    drv("t3f", 1, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0);

    // Clear ignored during the handshake, honoured in DONE.
    drv("t4a", 1, 8'h03, 0, 0, 0, 0, 0, 8'h00, 0);
    drv("t4b", 1, 8'h03, 0, 0, 0, 1, 0, 8'h03, 0);
    drv("t4c", 1, 8'h00, 1, 0, 0, 1, 0, 8'h03, 0);
    drv("t4d", 1, 8'h00, 1, 1, 0, 0, 0, 8'h03, 0);
    drv("t4e", 1, 8'h00, 1, 1, 0, 0, 0, 8'h03, 0);
    drv("t4f", 1, 8'h00, 0, 0, 0, 0, 1, 8'h03, 0);
    drv("t4g", 1, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0);
    // Clear coincident with trigger wins; counting restarts.
    drv("t4h", 1, 8'h08, 0, 0, 0, 0, 0, 8'h00, 0);
    drv("t4i", 1, 8'h08, 1, 0, 0, 0, 0, 8'h00, 0);
    drv("t4j", 1, 8'h08, 0, 0, 0, 0, 0, 8'h00, 0);
    drv("t4k", 1, 8'h08, 0, 0, 0, 1, 0, 8'h08, 3);

    // Asynchronous reset in HOLD.
    drv("t5a", 1, 8'h00, 0, 1, 0, 0, 0, 8'h08, 3);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_val("t5rst.req", 32'(req0), 32'd0);
    check_val("t5rst.fat", 32'(fat0), 32'd0);
    check_val("t5rst.vec", 32'(vec0), 32'd0);
    check_val("t5rst.idx", 32'(idx0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ack_in = 1'b0;
    drv("t5b", 1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0);
    drv("t5c", 1, 8'h20, 0, 0, 0, 0, 0, 8'h00, 0);
    drv("t5d", 1, 8'h20, 0, 0, 0, 1, 0, 8'h20, 5);
    drv("t5e", 1, 8'h20, 0, 1, 0, 0, 0, 8'h20, 5);
    drv("t5f", 1, 8'h00, 0, 0, 0, 0, 1, 8'h20, 5);

    // Enable dropped mid-FILTER restarts the filter.
    do_reset();
    drv("t5g", 1, 8'h40, 0, 0, 0, 0, 0, 8'h00, 0);
    drv("t5h", 0, 8'h40, 0, 0, 0, 0, 0, 8'h00, 0);
    drv("t5i", 1, 8'h40, 0, 0, 0, 0, 0, 8'h00, 0);
    drv("t5j", 1, 8'h40, 0, 0, 0, 1, 0, 8'h40, 6);

    // Disabled monitoring, then Threshold=1 alerts on the next cycle.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drv("t6off", 0, 8'hFF, 0, 0, 1, 0, 0, 8'h00, 0);
    end
    drv("t6on", 1, 8'hFF, 0, 0, 1, 1, 0, 8'hFF, 0);
    drv("t6b",  1, 8'h20, 0, 1, 1, 0, 0, 8'hFF, 0);
    drv("t6c",  1, 8'h00, 0, 0, 1, 0, 1, 8'hFF, 0);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
      @(posedge clk);
    end
    #3;
    check_val("drain", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
